scan_frame_scheduler: RTL
=========================

// Module: scan_frame_scheduler
// PURPOSE
//  Sequences the 16-channel frequency-count scan. For each channel it selects the input,
//  clears the counter, opens a gate window of GATE_TICKS baud ticks, and latches the count.
//  It then streams a 4-byte frame (header, channel, count, checksum) to the UART sender
//  over a valid/ready byte handshake. It sits between the baud divider, mux, counter and
//  uart_sender, and replaces the free-running 0.25 s timer coupling.
// PARAMETERS
//  NUM_CH      16     channels scanned; ch_sel width = clog2(NUM_CH)
//  GATE_TICKS  2400   gate length in tick_9600 pulses (2400 = 0.25 s)
//  CNT_W       8      width of the count input and count frame byte
//  HDR_BYTE    8'hA5  frame header byte
// PORTS
//  clk_in      in   1      system clock
//  reset       in   1      reset; asynchronous, active-low
//  tick_9600   in   1      one-clk_in-wide baud enable pulse
//  enable      in   1      run scan; sampled in IDLE and ADVANCE
//  ch_sel      out  4      channel select to input mux
//  cnt_clear   out  1      1-cycle pulse clearing the counter
//  gate        out  1      counter enable window
//  cnt_value   in   CNT_W  counter result
//  tx_data     out  8      byte to uart_sender
//  tx_valid    out  1      tx_data valid
//  tx_ready    in   1      uart_sender can accept a byte
//  frame_start out  1      1-cycle pulse when the header byte is first presented
//  scan_done   out  1      1-cycle pulse when ch_sel wraps NUM_CH-1 -> 0
//  busy        out  1      high in every state except IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, ch_sel=0, and all outputs, gate_cnt and latched count are 0.
//  - FSM: IDLE -> CLEAR -> GATE -> LATCH -> TX_HDR -> TX_CH -> TX_CNT -> TX_SUM -> ADVANCE.
//  - IDLE: go to CLEAR when enable=1.
//  - CLEAR: 1 cycle. cnt_clear=1, gate_cnt<=0.
//  - GATE: gate=1. gate_cnt increments on each tick_9600. Leave GATE on the cycle gate_cnt reaches
//    GATE_TICKS; gate therefore spans exactly GATE_TICKS ticks.
//  - LATCH: 1 cycle with gate=0. cnt_value is captured into cnt_q at the end of this cycle.
//  - TX_*: tx_valid=1 and tx_data is stable until the cycle tx_valid&&tx_ready=1.
//    The byte transfers on that cycle and the FSM advances the next cycle.
//    tx_valid never drops before the transfer completes.
//  - Frame bytes, in order: HDR_BYTE, {4'h0,ch_sel}, cnt_q, HDR_BYTE^{4'h0,ch_sel}^cnt_q (XOR).
//    CNT_W<8 is zero-extended; CNT_W>8 sends the low 8 bits.
//  - frame_start pulses on the first cycle of TX_HDR only, not on stalled cycles.
//  - ADVANCE: 1 cycle.
//    - ch_sel <= (ch_sel==NUM_CH-1) ? 0 : ch_sel+1.
//    - scan_done pulses on the wrap.
//    - Next state is CLEAR if enable=1, else IDLE.
//  - enable=0 mid-frame: the current frame completes; the FSM stops in IDLE with ch_sel already advanced.
//  - tick_9600 outside GATE is ignored.
//  - A tick on the same cycle GATE is entered counts as tick 1.
//  - Reset mid-frame aborts immediately; no partial-byte recovery is required.
//  - Per-channel latency with tx_ready held at 1: 1 (CLEAR) + gate + 1 (LATCH) + 4 + 1 (ADVANCE) clk_in cycles.
// CONFIGURATION
//  SCAN_MASK_EN defined:
//    - Adds input ch_mask[NUM_CH-1:0].
//    - ADVANCE moves to the next channel whose mask bit is 1, searching with wrap.
//    - scan_done pulses when the search passes channel NUM_CH-1.
//    - ch_mask=0: stay in or return to IDLE, with busy=0.
//    - ch_mask is sampled only in IDLE and ADVANCE.
//    - Leaving IDLE, if the current ch_sel is masked, first advance to the next enabled channel.
//  SCAN_MASK_EN undefined:
//    - No ch_mask port; all NUM_CH channels are scanned in order.
// TESTING
//  (bench: GATE_TICKS=4, tick_9600 every 3 clk_in)
//  1. Reset, enable=1, cnt_value=8'h12, tx_ready=1
//     -> cnt_clear pulse, gate high for 4 ticks, bytes A5,00,12,B7, then ch_sel=1.
//  2. tx_ready held low 5 cycles during TX_CNT
//     -> tx_valid=1 and tx_data=cnt_q stable all 5 cycles, exactly one transfer, frame_start pulsed once.
//  3. Run 16 frames -> ch_sel sequence 0..15, then 0; scan_done pulses once, on the 15->0 ADVANCE.
//  4. enable dropped during GATE of ch 3 -> frame for ch 3 completes, FSM enters IDLE, busy=0, ch_sel=4.
//  5. reset asserted during TX_CH -> all outputs 0 asynchronously, state IDLE, ch_sel=0.
//  6. SCAN_MASK_EN, ch_mask=16'h8001 -> frames only for ch 0 and 15, scan_done on 15->0;
//     ch_mask=0 -> busy=0.

Source files
------------

// File: rtl/scan_frame_scheduler.sv
// Frequency-count scan sequencer: per channel clear, gate, latch, then a 4-byte UART frame.
// Optional channel masking is enabled by defining SCAN_MASK_EN.
module scan_frame_scheduler #(
  parameter int NUM_CH = 16,
  parameter int GATE_TICKS = 2400,
  parameter int CNT_W = 8,
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick_9600,
  input  logic             enable,
`ifdef SCAN_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  output logic [CH_W-1:0]  ch_sel,
  output logic             cnt_clear,
  output logic             gate,
  input  logic [CNT_W-1:0] cnt_value,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             frame_start,
  output logic             scan_done,
  output logic             busy
);

  localparam int GW = $clog2(GATE_TICKS + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_TICKS - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [3:0] {
    IDLE, CLEAR, GATE, LATCH, TX_HDR, TX_CH, TX_CNT, TX_SUM, ADVANCE
  } state_t;

  state_t          state, state_nx;
  logic [CH_W-1:0] ch_nx;
  logic [GW-1:0]   gate_cnt;
  logic [CNT_W-1:0] cnt_q;
  logic            hdr_first;
  logic [7:0]      ch_byte, cnt_byte, sum_byte;

  // Zero-extend narrow values, keep the low byte of wide ones
  function automatic logic [7:0] cnt_to_byte(input logic [CNT_W-1:0] v);
    logic [CNT_W+7:0] ext;
    ext = {8'd0, v};
    return ext[7:0];
  endfunction

  function automatic logic [7:0] ch_to_byte(input logic [CH_W-1:0] v);
    logic [CH_W+7:0] ext;
    ext = {8'd0, v};
    return ext[7:0];
  endfunction

  assign ch_byte  = ch_to_byte(ch_sel);
  assign cnt_byte = cnt_to_byte(cnt_q);
  assign sum_byte = HDR_BYTE ^ ch_byte ^ cnt_byte;

`ifdef SCAN_MASK_EN
  logic [CH_W-1:0] srch_ch, cand;
  logic            srch_wrap, srch_found;

  // Next enabled channel after ch_sel, searching with wrap; wrap flags passing NUM_CH-1
  always_comb begin
    srch_ch    = ch_sel;
    srch_wrap  = 1'b0;
    srch_found = 1'b0;
    cand       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(ch_sel) + i) % NUM_CH);
      if (!srch_found && ch_mask[cand]) begin
        srch_found = 1'b1;
        srch_ch    = cand;
        srch_wrap  = (int'(ch_sel) + i) >= NUM_CH;
      end
    end
  end
`endif

  always_comb begin
    state_nx    = state;
    ch_nx       = ch_sel;
    cnt_clear   = 1'b0;
    gate        = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'd0;
    frame_start = 1'b0;
    scan_done   = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
`ifdef SCAN_MASK_EN
        if (enable && (|ch_mask)) begin
          state_nx = CLEAR;
          if (!ch_mask[ch_sel]) ch_nx = srch_ch;
        end
`else
        if (enable) state_nx = CLEAR;
`endif
      end
      CLEAR: begin
        cnt_clear = 1'b1;
        state_nx  = GATE;
      end
      GATE: begin
        gate = 1'b1;
        if (tick_9600 && gate_cnt >= GATE_LAST) state_nx = LATCH;
      end
      LATCH: state_nx = TX_HDR;
      TX_HDR: begin
        tx_valid    = 1'b1;
        tx_data     = HDR_BYTE;
        frame_start = hdr_first;
        if (tx_ready) state_nx = TX_CH;
      end
      TX_CH: begin
        tx_valid = 1'b1;
        tx_data  = ch_byte;
        if (tx_ready) state_nx = TX_CNT;
      end
      TX_CNT: begin
        tx_valid = 1'b1;
        tx_data  = cnt_byte;
        if (tx_ready) state_nx = TX_SUM;
      end
      TX_SUM: begin
        tx_valid = 1'b1;
        tx_data  = sum_byte;
        if (tx_ready) state_nx = ADVANCE;
      end
      ADVANCE: begin
`ifdef SCAN_MASK_EN
        if (|ch_mask) begin
          ch_nx     = srch_ch;
          scan_done = srch_wrap;
          state_nx  = enable ? CLEAR : IDLE;
        end else begin
          state_nx = IDLE;
        end
`else
        ch_nx     = (ch_sel == CH_LAST) ? '0 : ch_sel + CH_W'(1);
        scan_done = (ch_sel == CH_LAST);
        state_nx  = enable ? CLEAR : IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ch_sel    <= '0;
      gate_cnt  <= '0;
      cnt_q     <= '0;
      hdr_first <= 1'b0;
    end else begin
      state     <= state_nx;
      ch_sel    <= ch_nx;
      hdr_first <= (state == LATCH);
      if (state == CLEAR) gate_cnt <= '0;
      else if (state == GATE && tick_9600) gate_cnt <= gate_cnt + GW'(1);
      if (state == LATCH) cnt_q <= cnt_value;
    end
  end

endmodule
